// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
//   Shared definitions for the round-robin arbiter:
//     - arb_state_t : arbiter FSM states (IDLE, GNT)
//     - MAX_W       : widest requester vector the index encoder handles
//     - onehot_to_idx(): converts a one-hot vector to its bit index
package rr_arb_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } arb_state_t;

    // OR-ing the index of every set bit gives the exact index for a
    // one-hot input and 0 for an all-zero input, with no priority chain.
    function automatic int unsigned onehot_to_idx(input logic [MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_if.sv
// rr_arb_if
//   Request/grant handshake between the requester side and the arbiter.
//   Signals:
//     i_req     [W]     per-requester request level
//     i_ack             resource accepts the current grant
//     i_lock            (only with RR_ARB_LOCK_EN) keep grant after ack
//     o_gnt_vld         a grant is outstanding
//     o_gnt     [W]     one-hot grant
//     o_gnt_idx [IDX_W] encoded grant index
//   Modports: master (requester/resource side), slave (arbiter side).
//   Optional feature macro: RR_ARB_LOCK_EN.
interface rr_arb_if #(
    parameter int W = 4
);
    localparam int IDX_W = $clog2(W);

    logic [W-1:0]     i_req;
    logic             i_ack;
    logic             o_gnt_vld;
    logic [W-1:0]     o_gnt;
    logic [IDX_W-1:0] o_gnt_idx;

`ifdef RR_ARB_LOCK_EN
    logic             i_lock;

    modport master (
        output i_req, i_ack, i_lock,
        input  o_gnt_vld, o_gnt, o_gnt_idx
    );

    modport slave (
        input  i_req, i_ack, i_lock,
        output o_gnt_vld, o_gnt, o_gnt_idx
    );
`else
    modport master (
        output i_req, i_ack,
        input  o_gnt_vld, o_gnt, o_gnt_idx
    );

    modport slave (
        input  i_req, i_ack,
        output o_gnt_vld, o_gnt, o_gnt_idx
    );
`endif

endinterface

// File: rtl/rr_arb_pri.sv
// rr_arb_pri
//   Fixed-priority one-hot selector: the lowest-index set bit of i_req
//   wins. Output is one-hot, or zero when no bit is set.
//   Ports:
//     i_req [W]  candidate requests
//     o_sel [W]  one-hot selection
module rr_arb_pri #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_sel
);

    // x & -x isolates the lowest set bit.
    assign o_sel = i_req & (~i_req + W'(1));

endmodule

// File: rtl/rr_arb.sv
// rr_arb
//   Registered round-robin arbiter sharing one resource among W
//   requesters. A grant is held until acknowledged; on ack the winner
//   becomes lowest priority and a new winner is chosen in the same cycle,
//   giving one grant per cycle under continuous acks.
//   Ports:
//     clk     clock, rising edge
//     arst_n  asynchronous active-low reset
//     bus     rr_arb_if.slave handshake (i_req, i_ack, [i_lock],
//             o_gnt_vld, o_gnt, o_gnt_idx)
//   Optional feature macro: RR_ARB_LOCK_EN (ack with i_lock=1 keeps the
//   current grant without rotating priority).
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic     clk,
    input  logic     arst_n,
    rr_arb_if.slave  bus
);

    localparam int IDX_W = $clog2(W);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]     gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] arb_ptr;
    logic [W-1:0]     arb_req;
    logic [W-1:0]     mask;
    logic [W-1:0]     sel_masked;
    logic [W-1:0]     sel_unmasked;
    logic [W-1:0]     sel;
    logic [IDX_W-1:0] sel_idx;
    logic             rotate_ack;

    // An ack in GNT re-arbitrates as if ptr had already moved to the
    // winner and the winner's request were gone, so both are substituted
    // here rather than waiting a cycle for the registers to update.
    always_comb begin
        arb_ptr = ptr_q;
        arb_req = bus.i_req;
        if (state_q == GNT) begin
            arb_ptr = idx_q;
            arb_req = bus.i_req & ~gnt_q;
        end
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i > int'(arb_ptr));
        end
    end

    rr_arb_pri #(.W(W)) u_pri_masked (
        .i_req (arb_req & mask),
        .o_sel (sel_masked)
    );

    rr_arb_pri #(.W(W)) u_pri_unmasked (
        .i_req (arb_req),
        .o_sel (sel_unmasked)
    );

    // Requesters above the pointer win first; when none remain (including
    // the ptr=W-1 case where the mask is empty) fall back to the plain
    // lowest-index winner.
    assign sel     = (|sel_masked) ? sel_masked : sel_unmasked;
    assign sel_idx = IDX_W'(onehot_to_idx(MAX_W'(sel)));

`ifdef RR_ARB_LOCK_EN
    assign rotate_ack = bus.i_ack && !bus.i_lock;
`else
    assign rotate_ack = bus.i_ack;
`endif

    // Next-state logic: everything holds unless an arbitration point
    // (request in IDLE, or a rotating ack in GNT) is reached.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.i_req) begin
                    gnt_d   = sel;
                    vld_d   = 1'b1;
                    idx_d   = sel_idx;
                    state_d = GNT;
                end
            end
            GNT: begin
                if (rotate_ack) begin
                    ptr_d = idx_q;
                    if (|sel) begin
                        gnt_d = sel;
                        idx_d = sel_idx;
                    end else begin
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears an outstanding grant
    // immediately and restores requester 0 as highest priority.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(W - 1);
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_gnt_vld = vld_q;
    assign bus.o_gnt_idx = idx_q;

    // Protocol expectations on the requester side and output invariants.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!arst_n)
        $onehot0(gnt_q));

    a_vld_matches : assert property (@(posedge clk) disable iff (!arst_n)
        vld_q == (|gnt_q));

    a_ack_only_granted : assert property (@(posedge clk) disable iff (!arst_n)
        bus.i_ack |-> vld_q);

    a_req_held : assert property (@(posedge clk) disable iff (!arst_n)
        (vld_q && !bus.i_ack) |-> ((bus.i_req & gnt_q) == gnt_q));

    a_gnt_stable : assert property (@(posedge clk) disable iff (!arst_n)
        (vld_q && !bus.i_ack) |=> $stable(gnt_q));

endmodule
